// File: rtl/axi_burst_arbiter_pkg.sv
// axi_burst_arbiter_pkg: shared state and direction encodings for the burst arbiter.
package axi_burst_arbiter_pkg;
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_GAP  = 2'd2
    } arb_state_e;
    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } dir_e;
endpackage

// File: rtl/axi_burst_arbiter_if.sv
// axi_burst_arbiter_if: one burst command channel (request, address, length, done pulse).
interface axi_burst_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 12
);
    logic              rd_req;
    logic              wr_req;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  burst_length;
    logic              done;
    modport master (output rd_req, wr_req, addr, burst_length, input done);
    modport slave  (input rd_req, wr_req, addr, burst_length, output done);
endinterface

// File: rtl/axi_burst_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick; on a tie the requester other than last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);
    assign win[0] = req[0] & (~req[1] | last);
    assign win[1] = req[1] & (~req[0] | ~last);
endmodule

// File: rtl/axi_burst_arbiter.sv
// axi_burst_arbiter: shares one AXI burst master between two requesters, round-robin, one burst per grant.
// Optional macro AXI_ARB_WATCHDOG_EN forces completion after TIMEOUT busy cycles and sets timeout_err.
module axi_burst_arbiter
    import axi_burst_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 12,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                reset,
    axi_burst_arbiter_if.slave  req0,
    axi_burst_arbiter_if.slave  req1,
    axi_burst_arbiter_if.master axi,
    output logic [1:0]          gnt,
    output logic                busy,
    output logic                timeout_err
);
    arb_state_e        state, nxt;
    dir_e              dir;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic              owner, last, fin, tmo;
    logic [1:0]        win;

    rr_pick2 u_pick (
        .req ({req1.rd_req | req1.wr_req, req0.rd_req | req0.wr_req}),
        .last(last),
        .win (win)
    );

    assign busy             = state == ARB_BUSY;
    assign fin              = busy & (axi.done | tmo);
    assign gnt              = busy ? {owner, ~owner} : 2'b00;
    assign axi.rd_req       = busy & ~fin & (dir == DIR_RD);
    assign axi.wr_req       = busy & ~fin & (dir == DIR_WR);
    assign axi.addr         = addr_q;
    assign axi.burst_length = len_q;
    assign req0.done        = fin & ~owner;
    assign req1.done        = fin & owner;

    always_ff @(posedge clk) state <= reset ? ARB_IDLE : nxt;

    always_comb begin
        nxt = state;
        nxt = state == ARB_IDLE ? (|win ? ARB_BUSY : ARB_IDLE) :
              state == ARB_BUSY ? (fin ? ARB_GAP : ARB_BUSY) : ARB_IDLE;
    end

    // Command is captured once at grant so requester changes mid-burst cannot disturb it.
    always_ff @(posedge clk) begin
        if (reset) begin
            dir    <= DIR_RD;
            addr_q <= '0;
            len_q  <= '0;
            owner  <= 1'b0;
            last   <= 1'b1;
        end else begin
            if (state == ARB_IDLE && |win) begin
                owner  <= win[1];
                dir    <= (win[1] ? req1.rd_req : req0.rd_req) ? DIR_RD : DIR_WR;
                addr_q <= win[1] ? req1.addr : req0.addr;
                len_q  <= win[1] ? req1.burst_length : req0.burst_length;
            end
            if (fin) last <= owner;
        end
    end

`ifdef AXI_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          err;
    // cnt is zero on the first BUSY cycle, so the TIMEOUT-th busy cycle sees TIMEOUT-1.
    assign tmo         = busy & ~axi.done & (cnt == CW'(TIMEOUT - 1));
    assign timeout_err = err;
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= busy ? cnt + 1'b1 : '0;
            if (tmo) err <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
    assign tmo            = 1'b0;
    assign timeout_err    = 1'b0;
`endif
endmodule
